// File: rtl/arp_tx.sv
// ARP transmit: arbitrates reply/request slots and streams a 28-byte payload, one byte per cycle.
// First byte three edges after a slot pulse when the MAC is ready; once a frame starts it ignores i_mac_ready.
module arp_tx #(
  parameter logic [31:0] P_SRC_IP  = {8'd192, 8'd168, 8'd10, 8'd1},
  parameter logic [47:0] P_SRC_MAC = 48'h00_00_00_00_00_00
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_src_ip,
  input  logic        i_src_ip_valid,
  input  logic [47:0] i_src_mac,
  input  logic        i_src_mac_valid,
  input  logic [47:0] i_dst_mac,
  input  logic [31:0] i_dst_ip,
  input  logic        i_trig_reply,
  input  logic        i_arp_req,
  input  logic [31:0] i_req_ip,
  output logic        o_busy,
  output logic [47:0] o_mac_dst_mac,
  output logic [15:0] o_mac_type,
  output logic [7:0]  o_mac_data,
  output logic        o_mac_valid,
  output logic        o_mac_last,
  input  logic        i_mac_ready
);

  typedef enum logic [1:0] {IDLE, ARB, SEND, GAP} state_t;

  state_t state, state_nxt;
  logic [4:0]  cnt;
  logic        start, sel_reply;

  logic [31:0] src_ip;
  logic [47:0] src_mac;

  logic        pend_reply, pend_req;
  logic [47:0] rep_mac;
  logic [31:0] rep_ip;
  logic [31:0] req_ip;

  logic        f_reply;
  logic [47:0] f_dst_mac, f_smac, f_tha;
  logic [31:0] f_sip, f_tpa;

  logic [27:0][7:0] payload;
  logic             in_send;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    sel_reply = 1'b0;
    case (state)
      IDLE: if (pend_reply || pend_req) state_nxt = ARB;
      ARB: begin
        if (i_mac_ready) begin
          start     = 1'b1;
          sel_reply = pend_reply;
          state_nxt = SEND;
        end
      end
      SEND: if (cnt == 5'd27) state_nxt = GAP;
      GAP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      src_ip  <= P_SRC_IP;
      src_mac <= P_SRC_MAC;
    end else begin
      if (i_src_ip_valid)  src_ip  <= i_src_ip;
      if (i_src_mac_valid) src_mac <= i_src_mac;
    end
  end

  // A pulse coinciding with its slot's clear wins, so the slot re-arms with the new data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pend_reply <= 1'b0;
      pend_req   <= 1'b0;
      rep_mac    <= '0;
      rep_ip     <= '0;
      req_ip     <= '0;
    end else begin
      pend_reply <= i_trig_reply | (pend_reply & ~(start & sel_reply));
      pend_req   <= i_arp_req    | (pend_req   & ~(start & ~sel_reply));
      if (i_trig_reply) begin
        rep_mac <= i_dst_mac;
        rep_ip  <= i_dst_ip;
      end
      if (i_arp_req) req_ip <= i_req_ip;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      f_reply   <= 1'b0;
      f_dst_mac <= '0;
      f_smac    <= '0;
      f_sip     <= '0;
      f_tha     <= '0;
      f_tpa     <= '0;
      cnt       <= '0;
    end else begin
      if (start) begin
        f_reply   <= sel_reply;
        f_dst_mac <= sel_reply ? rep_mac : 48'hFFFF_FFFF_FFFF;
        f_smac    <= src_mac;
        f_sip     <= src_ip;
        f_tha     <= sel_reply ? rep_mac : 48'h0;
        f_tpa     <= sel_reply ? rep_ip : req_ip;
        cnt       <= '0;
      end else if (state == SEND && cnt != 5'd27) begin
        cnt <= cnt + 5'd1;
      end
    end
  end

  assign payload = {16'h0001, 16'h0800, 8'h06, 8'h04,
                    8'h00, (f_reply ? 8'h02 : 8'h01),
                    f_smac, f_sip, f_tha, f_tpa};

  assign in_send       = (state == SEND);
  assign o_mac_valid   = in_send;
  assign o_mac_data    = in_send ? payload[5'd27 - cnt] : 8'h00;
  assign o_mac_last    = in_send && (cnt == 5'd27);
  assign o_mac_dst_mac = in_send ? f_dst_mac : 48'h0;
  assign o_mac_type    = in_send ? 16'h0806 : 16'h0000;
  assign o_busy        = (state != IDLE) | pend_reply | pend_req;

endmodule

// File: tb/tb_arp_tx.sv
// Directed bench for arp_tx: stimulus pushes expected bytes to a scoreboard, a negedge monitor pops and compares.
module tb_arp_tx;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [31:0] i_src_ip;
  logic        i_src_ip_valid;
  logic [47:0] i_src_mac;
  logic        i_src_mac_valid;
  logic [47:0] i_dst_mac;
  logic [31:0] i_dst_ip;
  logic        i_trig_reply;
  logic        i_arp_req;
  logic [31:0] i_req_ip;
  logic        o_busy;
  logic [47:0] o_mac_dst_mac;
  logic [15:0] o_mac_type;
  logic [7:0]  o_mac_data;
  logic        o_mac_valid;
  logic        o_mac_last;
  logic        i_mac_ready;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0]  dat;
    logic        last;
    logic [47:0] dmac;
  } exp_t;
  exp_t sb[$];

  // Hand-assembled payloads (28 bytes each, byte 0 in the top bits).
  logic [223:0] f_reply1 = 224'h0001_0800_0604_0002_0200_0000_0001_C0A8_0A01_1122_3344_5566_C0A8_0A00;
  logic [223:0] f_req1   = 224'h0001_0800_0604_0001_0200_0000_0001_C0A8_0A01_0000_0000_0000_C0A8_0A05;
  logic [223:0] f_reply2 = 224'h0001_0800_0604_0002_0200_0000_0001_C0A8_0A09_AABB_CCDD_EEFF_C0A8_0A00;
  logic [223:0] f_reply3 = 224'h0001_0800_0604_0002_0200_0000_0001_C0A8_0A09_1122_3344_5566_C0A8_0A00;
  logic [223:0] f_reply4 = 224'h0001_0800_0604_0002_0000_0000_0000_C0A8_0A01_1122_3344_5566_C0A8_0A00;

  arp_tx dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_src_ip(i_src_ip), .i_src_ip_valid(i_src_ip_valid),
    .i_src_mac(i_src_mac), .i_src_mac_valid(i_src_mac_valid),
    .i_dst_mac(i_dst_mac), .i_dst_ip(i_dst_ip),
    .i_trig_reply(i_trig_reply), .i_arp_req(i_arp_req), .i_req_ip(i_req_ip),
    .o_busy(o_busy), .o_mac_dst_mac(o_mac_dst_mac), .o_mac_type(o_mac_type),
    .o_mac_data(o_mac_data), .o_mac_valid(o_mac_valid), .o_mac_last(o_mac_last),
    .i_mac_ready(i_mac_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [223:0] v, input logic [47:0] dmac, input int nbytes);
    exp_t e;
    for (int i = 0; i < nbytes; i++) begin
      e.dat  = v[223 - 8*i -: 8];
      e.last = (i == 27);
      e.dmac = dmac;
      sb.push_back(e);
    end
  endtask

  always @(negedge i_clk) begin : monitor
    exp_t e;
    if (!i_rst) begin
      if (o_mac_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %h expected no byte at %0t", o_mac_data, $time);
        end else begin
          e = sb.pop_front();
          chk("byte_dat", {56'h0, o_mac_data}, {56'h0, e.dat});
          chk("byte_last", {63'h0, o_mac_last}, {63'h0, e.last});
          chk("dst_mac", {16'h0, o_mac_dst_mac}, {16'h0, e.dmac});
          chk("mac_type", {48'h0, o_mac_type}, 64'h0806);
        end
      end else begin
        chk("idle_dst_mac", {16'h0, o_mac_dst_mac}, 64'h0);
        chk("idle_type", {48'h0, o_mac_type}, 64'h0);
        chk("idle_last", {63'h0, o_mac_last}, 64'h0);
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, {63'h0, o_mac_valid}, 64'h0);
    chk({tag, "_busy"}, {63'h0, o_busy}, 64'h0);
    chk({tag, "_data"}, {56'h0, o_mac_data}, 64'h0);
    chk({tag, "_last"}, {63'h0, o_mac_last}, 64'h0);
    chk({tag, "_dst_mac"}, {16'h0, o_mac_dst_mac}, 64'h0);
    chk({tag, "_type"}, {48'h0, o_mac_type}, 64'h0);
  endtask

  task automatic pulse(input logic rep, input logic req);
    @(posedge i_clk); #1;
    i_trig_reply = rep;
    i_arp_req    = req;
    @(posedge i_clk); #1;
    i_trig_reply = 1'b0;
    i_arp_req    = 1'b0;
  endtask

  // Launch a pulse just after edge T and count edges until valid is seen.
  task automatic launch_measure(input logic rep, input logic req, output int n);
    @(posedge i_clk); #1;
    i_trig_reply = rep;
    i_arp_req    = req;
    n = 0;
    while (n < 40) begin
      @(posedge i_clk); n++; #1;
      if (n == 1) begin
        i_trig_reply = 1'b0;
        i_arp_req    = 1'b0;
      end
      @(negedge i_clk);
      if (o_mac_valid) break;
    end
  endtask

  task automatic wait_q(input int n, input int budget, input string name);
    int k = 0;
    while (sb.size() > n && k < budget) begin
      @(negedge i_clk); #1;
      k++;
    end
    chk(name, 64'(sb.size()), 64'(n));
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (o_busy && k < budget) begin
      @(negedge i_clk);
      k++;
    end
    chk(name, {63'h0, o_busy}, 64'h0);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int k = 0;
    while (k < budget) begin
      @(negedge i_clk);
      if (o_mac_valid) break;
      k++;
    end
    chk(name, {63'h0, o_mac_valid}, 64'h1);
  endtask

  initial begin
    int n;
    i_rst = 1'b1;
    i_src_ip = '0; i_src_ip_valid = 1'b0;
    i_src_mac = '0; i_src_mac_valid = 1'b0;
    i_dst_mac = 48'h1122_3344_5566; i_dst_ip = 32'hC0A8_0A00;
    i_trig_reply = 1'b0; i_arp_req = 1'b0; i_req_ip = 32'hC0A8_0A05;
    i_mac_ready = 1'b1;

    repeat (2) @(posedge i_clk);
    #1 chk_zero("reset");
    @(posedge i_clk); #1 i_rst = 1'b0;

    @(posedge i_clk); #1;
    i_src_mac = 48'h0200_0000_0001; i_src_mac_valid = 1'b1;
    @(posedge i_clk); #1 i_src_mac_valid = 1'b0;

    // Reply frame with latency check.
    push_frame(f_reply1, 48'h1122_3344_5566, 28);
    launch_measure(1'b1, 1'b0, n);
    chk("reply_latency", 64'(n), 64'd3);
    wait_q(0, 60, "reply_drain");
    wait_idle(10, "reply_idle");

    // Broadcast request.
    push_frame(f_req1, 48'hFFFF_FFFF_FFFF, 28);
    launch_measure(1'b0, 1'b1, n);
    chk("req_latency", 64'(n), 64'd3);
    wait_q(0, 60, "req_drain");
    wait_idle(10, "req_idle");

    // Simultaneous: reply first, then request; busy held through the request's gap.
    push_frame(f_reply1, 48'h1122_3344_5566, 28);
    push_frame(f_req1, 48'hFFFF_FFFF_FFFF, 28);
    pulse(1'b1, 1'b1);
    wait_q(28, 60, "both_first_drain");
    @(negedge i_clk);
    chk("both_gap1_valid", {63'h0, o_mac_valid}, 64'h0);
    chk("both_gap1_busy", {63'h0, o_busy}, 64'h1);
    @(negedge i_clk);
    chk("both_idle_busy", {63'h0, o_busy}, 64'h1);
    wait_q(0, 60, "both_second_drain");
    @(negedge i_clk);
    chk("both_gap2_valid", {63'h0, o_mac_valid}, 64'h0);
    chk("both_gap2_busy", {63'h0, o_busy}, 64'h1);
    @(negedge i_clk);
    chk("both_end_busy", {63'h0, o_busy}, 64'h0);

    // MAC not ready: hold in ARB, then start one cycle after ready rises.
    i_mac_ready = 1'b0;
    push_frame(f_req1, 48'hFFFF_FFFF_FFFF, 28);
    pulse(1'b0, 1'b1);
    repeat (10) begin
      @(negedge i_clk);
      chk("ready_low_valid", {63'h0, o_mac_valid}, 64'h0);
    end
    @(posedge i_clk); #1 i_mac_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("ready_start", {63'h0, o_mac_valid}, 64'h1);
    wait_q(0, 60, "ready_drain");
    wait_idle(10, "ready_idle");

    // Mid-frame slot and local IP updates only affect the next frame.
    push_frame(f_reply1, 48'h1122_3344_5566, 28);
    push_frame(f_reply2, 48'hAABB_CCDD_EEFF, 28);
    pulse(1'b1, 1'b0);
    wait_valid(10, "mid_start");
    repeat (10) @(posedge i_clk);
    #1 i_dst_mac = 48'hAABB_CCDD_EEFF; i_trig_reply = 1'b1;
    @(posedge i_clk); #1 i_trig_reply = 1'b0;
    @(posedge i_clk); #1 i_src_ip = 32'hC0A8_0A09; i_src_ip_valid = 1'b1;
    @(posedge i_clk); #1 i_src_ip_valid = 1'b0;
    wait_q(0, 120, "mid_drain");
    wait_idle(10, "mid_idle");

    // Reset at byte 15 aborts; the next frame uses the reset-default local addresses.
    i_dst_mac = 48'h1122_3344_5566;
    push_frame(f_reply3, 48'h1122_3344_5566, 15);
    pulse(1'b1, 1'b0);
    wait_valid(10, "abort_start");
    repeat (15) @(posedge i_clk);
    #1 i_rst = 1'b1;
    #1 chk_zero("abort");
    chk("abort_q", 64'(sb.size()), 64'h0);
    @(posedge i_clk); #1 i_rst = 1'b0;
    push_frame(f_reply4, 48'h1122_3344_5566, 28);
    pulse(1'b1, 1'b0);
    wait_q(0, 60, "post_reset_drain");
    wait_idle(10, "post_reset_idle");

    repeat (3) @(negedge i_clk);
    chk("final_q", 64'(sb.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arp_tx.md
Name: arp_tx

Overview:
- ARP transmit stage; consumes the capture outputs of the ARP receive stage (requester MAC/IP and reply trigger) plus locally-issued resolve requests.
- Builds 28-byte ARP payloads (reply or request) and streams them byte-wise to the MAC transmit layer, together with frame-level destination MAC and EtherType.
- One frame in flight; one pending slot each for reply and request.

Parameters:
- P_SRC_IP, {8'd192,8'd168,8'd10,8'd1}, local IP after reset
- P_SRC_MAC, 48'h00_00_00_00_00_00, local MAC after reset

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_src_ip  in  32  new local IP
- i_src_ip_valid  in  1  load i_src_ip
- i_src_mac  in  48  new local MAC
- i_src_mac_valid  in  1  load i_src_mac
- i_dst_mac  in  48  requester MAC from receive stage
- i_dst_ip  in  32  requester IP from receive stage
- i_trig_reply  in  1  one-cycle pulse: send reply to i_dst_mac/i_dst_ip
- i_arp_req  in  1  one-cycle pulse: broadcast request for i_req_ip
- i_req_ip  in  32  IP to resolve
- o_busy  out  1  frame in progress or any slot pending
- o_mac_dst_mac  out  48  Ethernet destination for current frame
- o_mac_type  out  16  EtherType, 16'h0806 during frame
- o_mac_data  out  8  payload byte
- o_mac_valid  out  1  byte valid
- o_mac_last  out  1  final byte (index 27)
- i_mac_ready  in  1  MAC layer can accept a new frame

Behaviour:
- Reset: all outputs 0; local IP/MAC = parameters; pending slots cleared; FSM IDLE. Reset mid-frame aborts immediately; no resume.
- Local IP/MAC registers update on their valid pulses at any time; each frame snapshots them at frame start (entry to SEND), so mid-frame updates affect the next frame only.
- Reply slot: on i_trig_reply, set pend_reply and latch i_dst_mac/i_dst_ip. Request slot: on i_arp_req, set pend_req and latch i_req_ip. A repeat pulse while its slot is pending overwrites the latched data; it does not queue a second frame.
- A slot pulse on the same edge as that slot's clear (frame start) re-arms the slot with the new data.
- FSM states:
  - IDLE: if any slot pending, go to ARB.
  - ARB: if i_mac_ready=1, select the reply slot if pending (reply has priority), else the request slot; clear the selected slot, snapshot its fields, cnt=0, go to SEND. If i_mac_ready=0, stay in ARB.
  - SEND: one byte per cycle, no backpressure once started; cnt 0..27. At cnt=27, go to GAP.
  - GAP: one idle cycle with o_mac_valid=0, then go to IDLE.
- Latency: a pulse on edge T with the FSM idle and i_mac_ready high gives o_mac_valid=1 from edge T+3 (IDLE at T+1, ARB at T+2, SEND from T+3), for exactly 28 cycles.
- Byte map, big-endian:
  - bytes 0-1: 00 01
  - bytes 2-3: 08 00
  - byte 4: 06; byte 5: 04
  - bytes 6-7: opcode; reply = 00 02, request = 00 01
  - bytes 8-13: local MAC
  - bytes 14-17: local IP
  - bytes 18-23: reply = requester MAC; request = 00 × 6
  - bytes 24-27: reply = requester IP; request = i_req_ip
- o_mac_last=1 only with byte 27. o_mac_dst_mac is the requester MAC (reply) or 48'hFFFF_FFFF_FFFF (request). o_mac_dst_mac and o_mac_type are stable for the whole SEND state and 0 otherwise.
- o_busy = (state != IDLE) | pend_reply | pend_req.
- cnt is 5 bits, cleared at ARB exit; it never wraps within a frame.

Test Plan:
- Reply: local IP 192.168.10.1, local MAC 02:00:00:00:00:01; pulse i_trig_reply with dst_mac 11:22:33:44:55:66, dst_ip C0A80A00, ready=1 -> 28 bytes starting at edge T+3: 00 01 08 00 06 04 00 02 02 00 00 00 00 01 C0 A8 0A 01 11 22 33 44 55 66 C0 A8 0A 00; last on byte 27; dst_mac 112233445566; type 0806.
- Request: pulse i_arp_req with i_req_ip C0A80A05 -> opcode 00 01, bytes 18-23 all 00, bytes 24-27 C0 A8 0A 05, o_mac_dst_mac FFFFFFFFFFFF.
- Simultaneous i_trig_reply and i_arp_req -> reply frame first, one GAP cycle, ARB, then request frame; o_busy falls only after the request frame's GAP.
- i_mac_ready held low for 10 cycles after the trigger -> o_mac_valid stays 0; frame starts 1 cycle after ready rises; no bytes are lost or duplicated.
- Second i_trig_reply (new MAC aa:bb:cc:dd:ee:ff) during frame byte 10, plus i_src_ip_valid with C0A80A09 at byte 12 -> the current frame is unchanged; the next reply uses aa:bb:cc:dd:ee:ff and sender IP C0A80A09.
- Assert i_rst at byte 15 -> all outputs 0 immediately, o_busy=0; a new trigger after release yields a complete, correct frame.
